mul_iter: RTL and testbench
===========================

MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port valid, input, 1, start request; sampled only when idle.
REQ-005 SHALL have port op, input, 2, operation: 00 MUL (low half), 01 MULH (signed x signed, high), 10 MULHSU (signed x unsigned, high), 11 MULHU (unsigned x unsigned, high).
REQ-006 SHALL have port multiplicand, input, DATA_LEN, operand A (signed for MULH/MULHSU).
REQ-007 SHALL have port multiplier, input, DATA_LEN, operand B (signed for MULH only).
REQ-008 SHALL have port result, output, DATA_LEN, registered selected product half.
REQ-009 SHALL have port ready, output, 1, registered one-cycle completion pulse.
REQ-010 SHALL have port busy, output, 1, high while an operation is in flight (state != IDLE).

Function
REQ-011 SHALL implement an FSM with states IDLE, CALC, DONE.
REQ-012 IDLE: on valid=1, SHALL latch |A| and |B| (two's-complement negation only where the operand is signed per op and its MSB is 1), latch op, latch neg = signA XOR signB (signed operands only), clear accumulator and counter, go to CALC.
REQ-013 MUL low half SHALL be computed like MULH (signed magnitudes); low half is sign-independent, so the result is identical.
REQ-014 CALC: each cycle, if multiplier LSB is 1, add |A| to the upper accumulator half, then shift the {accumulator, multiplier} pair right by one; the accumulator SHALL be DATA_LEN+1 bits to hold the add carry.
REQ-015 CALC SHALL last exactly DATA_LEN cycles (counter 0..DATA_LEN-1), then go to DONE; no early termination on zero operands.
REQ-016 DONE: SHALL negate the full 2*DATA_LEN-bit product when neg=1, register the high half (op!=00) or low half (op=00) into result, assert ready on the next cycle, go to IDLE.
REQ-017 Latency: valid sampled in cycle 0 -> ready=1 in cycle DATA_LEN+2 (cycle 34 for DATA_LEN=32), for exactly one cycle.
REQ-018 result SHALL hold its value until the next ready pulse overwrites it.
REQ-019 valid while busy=1 SHALL be ignored; operands and op need not be held after the sampling cycle.
REQ-020 valid in the cycle ready=1 (state IDLE) SHALL be accepted; back-to-back throughput is one operation per DATA_LEN+2 cycles.
REQ-021 Most-negative operands SHALL be handled: |0x80000000| = 0x80000000 as an unsigned magnitude; products up to (2^DATA_LEN-1)^2 SHALL not overflow.

Reset
REQ-022 rst=1 SHALL force state IDLE, result=0, ready=0, busy=0, and clear the accumulator, counter and latched operands.
REQ-023 rst asserted mid-operation SHALL abort the operation with no ready pulse; valid in the same cycle as rst SHALL be ignored.
REQ-024 The first valid after rst deasserts SHALL be accepted normally.

Verification
REQ-025 MUL, A=7, B=6, valid in cycle 0 -> ready=1 in cycle 34 only, result=0x0000002A, busy high in cycles 1-33.
REQ-026 A=0x80000000, B=0x80000000: MULH -> 0x40000000; MUL -> 0x00000000; MULHU -> 0x40000000.
REQ-027 A=0xFFFFFFFF, B=0xFFFFFFFF: MULHSU -> 0xFFFFFFFF; MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MUL -> 0x00000001.
REQ-028 MUL 3x5 started; valid with MUL 9x9 pulsed in cycle 10 -> ignored, cycle 34 result=0x0000000F; valid with MUL 9x9 in cycle 34 -> accepted, cycle 68 result=0x00000051.
REQ-029 MULH A=0xFFFFFFFE (-2), B=3 -> 0xFFFFFFFF; MUL -> 0xFFFFFFFA.
REQ-030 Start MUL 7x6, rst in cycle 15 -> no ready pulse, result=0, busy=0 from cycle 16; new MUL 2x2 in cycle 17 -> ready in cycle 51, result=0x00000004.

Source files
------------

// File: rtl/mul_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mul_iter                                                       |
// | Brief   : Iterative shift-add multiplier with the four RISC-V M ops:     |
// |           MUL, MULH, MULHSU and MULHU. It multiplies operand magnitudes  |
// |           one bit per cycle and applies the sign at the end.             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mul_iter #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [1:0]          op,
  input  logic [DATA_LEN-1:0] multiplicand,
  input  logic [DATA_LEN-1:0] multiplier,
  output logic [DATA_LEN-1:0] result,
  output logic                ready,
  output logic                busy
);

  localparam int c_CNT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_LEN - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [1:0] c_OP_MUL    = 2'b00;
  localparam logic [1:0] c_OP_MULHU  = 2'b11;

  logic [1:0]            r_state;
  logic [1:0]            r_op;
  logic                  r_neg;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [DATA_LEN-1:0]   r_mcand;
  // Multiplier bits are consumed from the LSB; product low bits fill in from the MSB.
  logic [DATA_LEN-1:0]   r_mplr;
  // One extra bit so the add carry survives until the right shift.
  logic [DATA_LEN:0]     r_acc;
  logic [DATA_LEN-1:0]   r_result;
  logic                  r_ready;

  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_LEN-1:0]   w_a_mag;
  logic [DATA_LEN-1:0]   w_b_mag;
  logic [DATA_LEN-1:0]   w_addend;
  logic [DATA_LEN:0]     w_sum;
  logic [2*DATA_LEN-1:0] w_prod_mag;
  logic [2*DATA_LEN-1:0] w_prod;

  // MUL is treated as signed x signed: the low half does not depend on signedness.
  // A is signed for everything except MULHU; B is signed only for MUL/MULH.
  assign w_a_neg = (op != c_OP_MULHU) && multiplicand[DATA_LEN-1];
  assign w_b_neg = (op[1] == 1'b0) && multiplier[DATA_LEN-1];

  // Negating the most-negative value yields the same bit pattern, which is the
  // correct unsigned magnitude, so no special case is needed.
  assign w_a_mag = w_a_neg ? (~multiplicand + 1'b1) : multiplicand;
  assign w_b_mag = w_b_neg ? (~multiplier + 1'b1) : multiplier;

  assign w_addend   = r_mplr[0] ? r_mcand : '0;
  assign w_sum      = r_acc + {1'b0, w_addend};
  assign w_prod_mag = {r_acc[DATA_LEN-1:0], r_mplr};
  assign w_prod     = r_neg ? (~w_prod_mag + 1'b1) : w_prod_mag;

  // Sequencer and datapath: latch magnitudes, shift-add for DATA_LEN cycles, sign and select.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_op     <= 2'b00;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (valid) begin
            r_mcand <= w_a_mag;
            r_mplr  <= w_b_mag;
            r_op    <= op;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= c_CALC;
          end
        end
        c_CALC: begin
          r_acc  <= {1'b0, w_sum[DATA_LEN:1]};
          r_mplr <= {w_sum[0], r_mplr[DATA_LEN-1:1]};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          r_result <= (r_op == c_OP_MUL) ? w_prod[DATA_LEN-1:0]
                                         : w_prod[2*DATA_LEN-1:DATA_LEN];
          r_ready  <= 1'b1;
          r_state  <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign result = r_result;
  assign ready  = r_ready;
  assign busy   = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_mul_iter                                                    |
// | Brief   : Self-checking bench for mul_iter: vector table, random ops    |
// |           against a wide-multiply model, and timing corner sequences.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mul_iter;

  localparam int DATA_LEN = 32;
  localparam int c_LAT    = DATA_LEN + 2;

  logic                clk;
  logic                rst;
  logic                valid;
  logic [1:0]          op;
  logic [DATA_LEN-1:0] multiplicand;
  logic [DATA_LEN-1:0] multiplier;
  logic [DATA_LEN-1:0] result;
  logic                ready;
  logic                busy;

  mul_iter #(.DATA_LEN(DATA_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid),
    .op           (op),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .result       (result),
    .ready        (ready),
    .busy         (busy)
  );

  typedef struct {
    logic [1:0]          op;
    logic [DATA_LEN-1:0] a;
    logic [DATA_LEN-1:0] b;
    logic [DATA_LEN-1:0] exp;
  } vec_t;

  typedef struct {
    logic [DATA_LEN-1:0] res;
    int                  cyc;
  } sb_t;

  sb_t                 sb[$];
  int                  checks = 0;
  int                  errors = 0;
  int                  cyc    = 0;
  bit                  mon_en = 0;
  logic [DATA_LEN-1:0] hold_val = '0;
  vec_t                vecs[12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number; inputs driven while cyc == N are sampled at the end of cycle N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent model: full-width multiply of properly extended operands.
  function automatic logic [DATA_LEN-1:0] ref_mul(input logic [1:0] o,
                                                  input logic [DATA_LEN-1:0] a,
                                                  input logic [DATA_LEN-1:0] b);
    logic [2*DATA_LEN-1:0] ea, eb, p;
    ea = (o != 2'b11) ? {{DATA_LEN{a[DATA_LEN-1]}}, a} : {{DATA_LEN{1'b0}}, a};
    eb = (o[1] == 1'b0) ? {{DATA_LEN{b[DATA_LEN-1]}}, b} : {{DATA_LEN{1'b0}}, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[DATA_LEN-1:0] : p[2*DATA_LEN-1:DATA_LEN];
  endfunction

  // Scoreboard monitor: every ready pulse must match the oldest expected entry
  // in value and cycle; between pulses result must hold its last value.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 64'(ready), 64'(0));
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("result", 64'(result), 64'(e.res));
          check("ready_cycle", 64'(cyc), 64'(e.cyc));
          hold_val = e.res;
        end
      end else begin
        check("result_hold", 64'(result), 64'(hold_val));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic start(input logic [1:0] o, input logic [DATA_LEN-1:0] a,
                       input logic [DATA_LEN-1:0] b, input logic [DATA_LEN-1:0] exp,
                       input bit push);
    valid        = 1'b1;
    op           = o;
    multiplicand = a;
    multiplier   = b;
    if (push) sb.push_back('{res: exp, cyc: cyc + c_LAT});
    tick();
    valid        = 1'b0;
    op           = 2'($urandom);
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3 * c_LAT) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
  endtask

  initial begin
    int c;
    vecs[0]  = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
    vecs[1]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[3]  = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[4]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[6]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[8]  = '{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
    vecs[9]  = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA};
    vecs[10] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};

    rst = 1'b1; valid = 1'b0; op = 2'b00; multiplicand = '0; multiplier = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_result", 64'(result), 64'(0));
    check("reset_ready",  64'(ready),  64'(0));
    check("reset_busy",   64'(busy),   64'(0));
    mon_en = 1'b1;

    // MUL 7x6: busy through cycles 1..33, idle in the ready cycle.
    c = cyc;
    start(2'b00, 32'd7, 32'd6, 32'h2A, 1'b1);
    for (int i = 1; i <= c_LAT - 1; i++) begin
      check("busy_in_flight", 64'(busy), 64'(1));
      tick();
    end
    check("busy_at_ready", 64'(busy), 64'(0));
    wait_drain();

    // Table of directed vectors.
    for (int i = 0; i < 12; i++) begin
      start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
      wait_drain();
    end

    // Random operations against the model.
    for (int i = 0; i < 10; i++) begin
      logic [1:0]          ro;
      logic [DATA_LEN-1:0] ra, rb;
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      start(ro, ra, rb, ref_mul(ro, ra, rb), 1'b1);
      wait_drain();
    end

    // Valid while busy is ignored; valid in the ready cycle is accepted.
    c = cyc;
    start(2'b00, 32'd3, 32'd5, 32'h0000_000F, 1'b1);
    tick_until(c + 10);
    start(2'b00, 32'd9, 32'd9, 32'h0, 1'b0);
    tick_until(c + c_LAT);
    check("ready_cycle_b2b", 64'(ready), 64'(1));
    start(2'b00, 32'd9, 32'd9, 32'h0000_0051, 1'b1);
    wait_drain();

    // Reset mid-operation aborts it; valid alongside rst is ignored.
    c = cyc;
    start(2'b00, 32'd7, 32'd6, 32'h0, 1'b0);
    tick_until(c + 15);
    rst = 1'b1; valid = 1'b1; op = 2'b00; multiplicand = 32'd5; multiplier = 32'd5;
    tick();
    rst = 1'b0; valid = 1'b0;
    hold_val = '0;
    check("abort_result", 64'(result), 64'(0));
    check("abort_busy",   64'(busy),   64'(0));
    check("abort_ready",  64'(ready),  64'(0));
    tick_until(c + 17);
    start(2'b00, 32'd2, 32'd2, 32'h0000_0004, 1'b1);
    wait_drain();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
